// File: rtl/cpu.sv
// cpu: 5-stage pipelined CPU; one system cycle per 32 CLK.
// Define CPU_FORWARD_EN to forward EX operands from EX/MEM and MEM/WB.
package cpu_pkg;
   typedef enum logic [3:0] {
      OP_NOP,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_MUL,
      OP_ADDI,
      OP_LW,
      OP_SW
   } op_e;

   typedef struct packed {
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      op_e         op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic        we;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
   } id_ex_t;

   typedef struct packed {
      op_e         op;
      logic [4:0]  dst;
      logic        we;
      logic [31:0] res;
      logic [31:0] sdata;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0]  dst;
      logic        we;
      logic [31:0] data;
   } mem_wb_t;
endpackage

module cpu
   import cpu_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Prog_BUS_READ,
   input  logic [31:0] Data_BUS_READ,
   output logic [31:0] ADDR,
   output logic        CS,
   output logic        CS_P,
   output logic        WR_RD,
   output logic [31:0] Data_BUS_WRITE
);

`ifdef CPU_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_q, fetch_d;
   if_id_t      if_id_q, if_id_d;
   id_ex_t      id_ex_q, id_ex_d;
   ex_mem_t     ex_mem_q, ex_mem_d;
   mem_wb_t     mem_wb_q, mem_wb_d;
   logic [31:0] mul_q, mul_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic        wrap;
   logic        phase_b;

   assign wrap    = (cnt_q == 5'd31);
   assign phase_b = cnt_q[4];

   // Fetch word is sampled mid-cycle, handed to ID at the wrap edge
   always_comb begin
      cnt_d   = cnt_q + 5'd1;
      pc_d    = wrap ? pc_q + 32'd1 : pc_q;
      fetch_d = (cnt_q == 5'd15) ? Prog_BUS_READ : fetch_q;
      if_id_d = if_id_q;
      if (wrap) if_id_d.instr = fetch_q;
   end

   logic [5:0]  opc;
   logic [5:0]  fn;
   logic [4:0]  f_rs;
   logic [4:0]  f_rt;
   logic [4:0]  f_rd;
   op_e         dec_op;
   logic [4:0]  dec_dst;
   logic [31:0] rs_rd;
   logic [31:0] rt_rd;

   always_comb begin
      opc     = if_id_q.instr[31:26];
      fn      = if_id_q.instr[5:0];
      f_rs    = if_id_q.instr[25:21];
      f_rt    = if_id_q.instr[20:16];
      f_rd    = if_id_q.instr[15:11];
      dec_op  = OP_NOP;
      dec_dst = 5'd0;
      unique case (1'b1)
         (opc == 6'h00) && (fn == 6'h20): dec_op = OP_ADD;
         (opc == 6'h00) && (fn == 6'h22): dec_op = OP_SUB;
         (opc == 6'h00) && (fn == 6'h24): dec_op = OP_AND;
         (opc == 6'h00) && (fn == 6'h25): dec_op = OP_OR;
         (opc == 6'h00) && (fn == 6'h18): dec_op = OP_MUL;
         (opc == 6'h08):                  dec_op = OP_ADDI;
         (opc == 6'h23):                  dec_op = OP_LW;
         (opc == 6'h2B):                  dec_op = OP_SW;
         default:                         dec_op = OP_NOP;
      endcase
      case (dec_op)
         OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_MUL:   dec_dst = f_rd;
         OP_ADDI, OP_LW:  dec_dst = f_rt;
         default:         dec_dst = 5'd0;
      endcase
      // Write-before-read: the WB result bypasses the file
      rs_rd = rf_q[f_rs];
      rt_rd = rf_q[f_rt];
      if (mem_wb_q.we && (mem_wb_q.dst == f_rs))
         rs_rd = mem_wb_q.data;
      if (mem_wb_q.we && (mem_wb_q.dst == f_rt))
         rt_rd = mem_wb_q.data;
      id_ex_d = id_ex_q;
      if (wrap) begin
         id_ex_d.op     = dec_op;
         id_ex_d.rs     = f_rs;
         id_ex_d.rt     = f_rt;
         id_ex_d.dst    = dec_dst;
         id_ex_d.we     = (dec_dst != 5'd0);
         id_ex_d.rs_val = rs_rd;
         id_ex_d.rt_val = rt_rd;
         id_ex_d.imm    = {{16{if_id_q.instr[15]}},
                           if_id_q.instr[15:0]};
      end
   end

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        fa_em, fa_mw;
   logic        fb_em, fb_mw;

   // A load's data only exists after MEM, so EX/MEM never forwards it
   always_comb begin
      fa_em = FWD_EN && ex_mem_q.we && (ex_mem_q.op != OP_LW)
              && (ex_mem_q.dst == id_ex_q.rs);
      fb_em = FWD_EN && ex_mem_q.we && (ex_mem_q.op != OP_LW)
              && (ex_mem_q.dst == id_ex_q.rt);
      fa_mw = FWD_EN && mem_wb_q.we
              && (mem_wb_q.dst == id_ex_q.rs);
      fb_mw = FWD_EN && mem_wb_q.we
              && (mem_wb_q.dst == id_ex_q.rt);
      op_a = id_ex_q.rs_val;
      op_b = id_ex_q.rt_val;
      if (fa_em)      op_a = ex_mem_q.res;
      else if (fa_mw) op_a = mem_wb_q.data;
      if (fb_em)      op_b = ex_mem_q.res;
      else if (fb_mw) op_b = mem_wb_q.data;
   end

   logic [31:0] part;

   // Shift-add: bit cnt of op_b during counts 0..15
   always_comb begin
      part  = op_b[cnt_q[3:0]]
              ? ({16'd0, op_a[15:0]} << cnt_q[3:0]) : 32'd0;
      mul_d = mul_q;
      if ((id_ex_q.op == OP_MUL) && !phase_b)
         mul_d = ((cnt_q == 5'd0) ? 32'd0 : mul_q) + part;
   end

   logic [31:0] ex_res;

   always_comb begin
      ex_res = 32'd0;
      case (id_ex_q.op)
         OP_ADD:  ex_res = op_a + op_b;
         OP_SUB:  ex_res = op_a - op_b;
         OP_AND:  ex_res = op_a & op_b;
         OP_OR:   ex_res = op_a | op_b;
         OP_MUL:  ex_res = mul_q;
         OP_ADDI,
         OP_LW,
         OP_SW:   ex_res = op_a + id_ex_q.imm;
         default: ex_res = 32'd0;
      endcase
      ex_mem_d = ex_mem_q;
      if (wrap) begin
         ex_mem_d.op    = id_ex_q.op;
         ex_mem_d.dst   = id_ex_q.dst;
         ex_mem_d.we    = id_ex_q.we;
         ex_mem_d.res   = ex_res;
         ex_mem_d.sdata = op_b;
      end
   end

   logic mem_act;
   logic mem_wr;

   always_comb begin
      mem_act  = (ex_mem_q.op == OP_LW) || (ex_mem_q.op == OP_SW);
      mem_wr   = (ex_mem_q.op == OP_SW);
      mem_wb_d = mem_wb_q;
      if (wrap) begin
         mem_wb_d.dst  = ex_mem_q.dst;
         mem_wb_d.we   = ex_mem_q.we;
         mem_wb_d.data = (ex_mem_q.op == OP_LW)
                         ? Data_BUS_READ : ex_mem_q.res;
      end
      ADDR           = pc_q;
      CS             = 1'b0;
      CS_P           = 1'b1;
      WR_RD          = 1'b0;
      Data_BUS_WRITE = 32'd0;
      if (phase_b) begin
         CS_P = 1'b0;
         ADDR = 32'd0;
         if (mem_act) begin
            ADDR           = ex_mem_q.res;
            CS             = 1'b1;
            WR_RD          = mem_wr;
            Data_BUS_WRITE = mem_wr ? ex_mem_q.sdata : 32'd0;
         end
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (wrap && mem_wb_q.we)
         rf_d[mem_wb_q.dst] = mem_wb_q.data;
      rf_d[0] = 32'd0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q    <= '0;
         pc_q     <= '0;
         fetch_q  <= '0;
         if_id_q  <= '0;
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
         mul_q    <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         fetch_q  <= fetch_d;
         if_id_q  <= if_id_d;
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
         mul_q    <= mul_d;
         rf_q     <= rf_d;
      end
   end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for cpu; expected stores are queued
// and a bus monitor pops and compares each store it observes.
module tb_cpu;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] Prog_BUS_READ;
   logic [31:0] Data_BUS_READ;
   logic [31:0] ADDR;
   logic        CS;
   logic        CS_P;
   logic        WR_RD;
   logic [31:0] Data_BUS_WRITE;

   cpu dut (
      .CLK           (CLK),
      .RST           (RST),
      .Prog_BUS_READ (Prog_BUS_READ),
      .Data_BUS_READ (Data_BUS_READ),
      .ADDR          (ADDR),
      .CS            (CS),
      .CS_P          (CS_P),
      .WR_RD         (WR_RD),
      .Data_BUS_WRITE(Data_BUS_WRITE)
   );

   always #5 CLK = ~CLK;

   logic [31:0] pmem [256];
   logic [31:0] dmem [256];

   // Off-phase bus values are poison: a stray SW or a bogus word
   always_comb begin
      Prog_BUS_READ = CS_P ? pmem[ADDR[7:0]] : 32'hAC00_0099;
      Data_BUS_READ = (CS && !WR_RD) ? dmem[ADDR[7:0]]
                                     : 32'hDEAD_BEEF;
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } st_t;

   st_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void expect_store(input logic [31:0] a,
                                        input logic [31:0] d);
      st_t s;
      s.addr = a;
      s.data = d;
      exp_q.push_back(s);
   endfunction

   function automatic logic [31:0] r_op(input int rs, input int rt,
                                        input int rd,
                                        input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op,
                                        input int rs, input int rt,
                                        input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic hold_reset();
      RST = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 256; i++) pmem[i] = 32'd0;
   endtask

   task automatic run(input int cycles);
      @(negedge CLK);
      RST = 1'b0;
      repeat (cycles * 32) @(negedge CLK);
      #1;
      chk("stores_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_addr"}, ADDR, 32'd0);
      chk({tag, "_cs"}, 32'(CS), 32'd0);
      chk({tag, "_csp"}, 32'(CS_P), 32'd1);
      chk({tag, "_wrrd"}, 32'(WR_RD), 32'd0);
      chk({tag, "_dbw"}, Data_BUS_WRITE, 32'd0);
   endtask

   initial begin : monitor
      logic seen;
      st_t  e;
      seen = 1'b0;
      forever begin
         @(negedge CLK);
         #1;
         if (CS && WR_RD && !seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_store: addr %h data %h",
                        ADDR, Data_BUS_WRITE);
            end else begin
               e = exp_q.pop_front();
               chk("store_addr", ADDR, e.addr);
               chk("store_data", Data_BUS_WRITE, e.data);
            end
         end
         seen = CS && WR_RD;
      end
   end

   initial begin : stim
      int hi;
      for (int i = 0; i < 256; i++) begin
         pmem[i] = 32'd0;
         dmem[i] = 32'd0;
      end
      dmem[8'h10] = 32'd4001;
      dmem[8'h11] = 32'd2001;
      dmem[8'h12] = 32'd5001;
      dmem[8'h13] = 32'd3001;

      RST = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      chk_reset_outs("reset");

      // NOP program: one fetch address per 32 CLK
      @(negedge CLK);
      RST = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         hi = 0;
         for (int i = 0; i < 32; i++) begin
            if (i == 0)  chk("fetch_addr", ADDR, 32'(k));
            if (i == 16) chk("phaseb_idle_addr", ADDR, 32'd0);
            if (CS_P) hi++;
            @(negedge CLK);
            #1;
         end
         chk("csp_high_clks", 32'(hi), 32'd16);
      end

      // Loads, subtracts and multiply, hazards padded with NOPs
      hold_reset();
      pmem[0]  = i_op(6'h23, 0, 1, 16'h0010);
      pmem[1]  = i_op(6'h23, 0, 2, 16'h0011);
      pmem[2]  = i_op(6'h23, 0, 3, 16'h0012);
      pmem[3]  = i_op(6'h23, 0, 4, 16'h0013);
      pmem[4]  = r_op(1, 2, 5, 6'h22);
      pmem[6]  = r_op(3, 4, 6, 6'h22);
      pmem[9]  = r_op(5, 6, 7, 6'h18);
      pmem[12] = i_op(6'h2B, 0, 7, 16'h1B2F);
      expect_store(32'h1B2F, 32'd4000000);
      run(20);

      // Same program packed tight
      hold_reset();
      pmem[0] = i_op(6'h23, 0, 1, 16'h0010);
      pmem[1] = i_op(6'h23, 0, 2, 16'h0011);
      pmem[2] = i_op(6'h23, 0, 3, 16'h0012);
      pmem[3] = i_op(6'h23, 0, 4, 16'h0013);
      pmem[4] = r_op(1, 2, 5, 6'h22);
      pmem[5] = r_op(3, 4, 6, 6'h22);
      pmem[6] = r_op(5, 6, 7, 6'h18);
      pmem[7] = i_op(6'h2B, 0, 7, 16'h1B2F);
`ifdef CPU_FORWARD_EN
      expect_store(32'h1B2F, 32'd4000000);
`else
      expect_store(32'h1B2F, 32'd0);
`endif
      run(15);

      // Arithmetic edges, r0, logic ops, undefined encodings
      hold_reset();
      pmem[0]  = i_op(6'h08, 0, 1, 16'hFFFF);
      pmem[1]  = i_op(6'h08, 0, 2, 16'h0001);
      pmem[2]  = i_op(6'h08, 0, 0, 16'h0005);
      pmem[4]  = r_op(1, 2, 5, 6'h20);
      pmem[5]  = r_op(1, 1, 4, 6'h18);
      pmem[6]  = r_op(0, 2, 6, 6'h20);
      pmem[7]  = i_op(6'h2B, 0, 5, 16'h0020);
      pmem[8]  = i_op(6'h2B, 0, 4, 16'h0021);
      pmem[9]  = i_op(6'h2B, 0, 6, 16'h0022);
      pmem[10] = r_op(0, 2, 7, 6'h22);
      pmem[11] = i_op(6'h08, 0, 10, 16'h00F0);
      pmem[12] = i_op(6'h08, 0, 11, 16'h0F3C);
      pmem[13] = i_op(6'h2B, 0, 7, 16'h0023);
      pmem[14] = i_op(6'h3F, 0, 13, 16'h0005);
      pmem[15] = r_op(10, 11, 8, 6'h24);
      pmem[16] = r_op(10, 11, 9, 6'h25);
      pmem[17] = r_op(1, 2, 12, 6'h3F);
      pmem[18] = i_op(6'h2B, 0, 8, 16'h0024);
      pmem[19] = i_op(6'h2B, 0, 9, 16'h0025);
      pmem[20] = i_op(6'h2B, 0, 12, 16'h0026);
      pmem[21] = i_op(6'h2B, 0, 13, 16'h0027);
      expect_store(32'h20, 32'h0000_0000);
      expect_store(32'h21, 32'hFFFE_0001);
      expect_store(32'h22, 32'h0000_0001);
      expect_store(32'h23, 32'hFFFF_FFFF);
      expect_store(32'h24, 32'h0000_0030);
      expect_store(32'h25, 32'h0000_0FFC);
      expect_store(32'h26, 32'h0000_0000);
      expect_store(32'h27, 32'h0000_0000);
      run(30);

      // Reset lands in the multiply's EX cycle
      hold_reset();
      pmem[0] = i_op(6'h08, 0, 1, 16'h0003);
      pmem[3] = r_op(1, 1, 2, 6'h18);
      pmem[6] = i_op(6'h2B, 0, 2, 16'h0030);
      @(negedge CLK);
      RST = 1'b0;
      repeat (5 * 32 + 8) @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk_reset_outs("abort");
      repeat (3) @(negedge CLK);
      chk("abort_no_store", 32'(exp_q.size()), 32'd0);
      expect_store(32'h30, 32'd9);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("restart_addr", ADDR, 32'd0);
      chk("restart_csp", 32'(CS_P), 32'd1);
      repeat (15 * 32) @(negedge CLK);
      #1;
      chk("restart_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 CLK  input  1  master clock; all state updates on its rising edge.
REQ-002 RST  input  1  reset; asynchronous, active-high.
REQ-003 Prog_BUS_READ  input  32  instruction word returned by the external program memory for ADDR while CS_P=1.
REQ-004 Data_BUS_READ  input  32  data word returned by the external data memory for ADDR while CS=1 and WR_RD=0.
REQ-005 ADDR  output  32  word address, time-multiplexed: program counter in phase A, data address in phase B.
REQ-006 CS  output  1  data-memory chip select; 1 only in phase B of a LW/SW memory stage.
REQ-007 CS_P  output  1  program-memory chip select; 1 throughout phase A.
REQ-008 WR_RD  output  1  data direction; 1=write (SW), 0=read.
REQ-009 Data_BUS_WRITE  output  32  store data; valid whenever WR_RD=1.

Function
REQ-010 Internal 5-bit free-running counter divides CLK by 32; one system cycle = 32 CLK; phase A = counts 0-15, phase B = counts 16-31.
REQ-011 Pipeline registers, PC and register file update once per system cycle, on the CLK edge where the counter wraps 31->0; no derived clock drives flip-flops.
REQ-012 Five stages IF, ID, EX, MEM, WB; PC word-addressed, +1 per system cycle; no branches or jumps.
REQ-013 IF latches Prog_BUS_READ at end of phase A.
REQ-014 Instruction format: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0].
REQ-015 Supported: R-type opcode 0 with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x18 MUL; 0x08 ADDI (imm sign-extended); 0x23 LW rt=M[rs+imm]; 0x2B SW M[rs+imm]=rt.
REQ-016 Any other opcode/funct, including 0x00000000, executes as NOP with no register or memory write.
REQ-017 ADD/SUB/ADDI wrap modulo 2^32; no overflow trap.
REQ-018 MUL: unsigned rs[15:0] x rt[15:0] -> 32-bit product to rd; sequential shift-add, one bit per CLK, starts at counter 0, done by counter 16, captured at end of the system cycle.
REQ-019 Register file 32x32, two read ports, one write port; r0 reads 0 and ignores writes; WB write is visible to ID in the same system cycle (write-before-read).
REQ-020 MEM stage in phase B: ADDR=effective address; LW: CS=1, WR_RD=0, Data_BUS_READ latched at end of phase B; SW: CS=1, WR_RD=1, Data_BUS_WRITE=rt value.
REQ-021 Outside an active memory phase: CS=0, WR_RD=0, Data_BUS_WRITE=0; in phase B with no memory op, ADDR=0.

Reset
REQ-022 While RST=1: counter=0, PC=0, all pipeline registers = NOP, multiplier cleared, registers r1-r31=0, ADDR=0, CS=0, WR_RD=0, Data_BUS_WRITE=0, CS_P=1.
REQ-023 RST mid-operation aborts any in-flight instruction, including a multiply, with no memory write; after release, fetch restarts at PC=0 with phase A.

Configuration
REQ-024 Macro CPU_FORWARD_EN defined: EX operands forwarded from EX/MEM (priority) then MEM/WB when a destination matches rs/rt and is not r0; LW result forwarded only from MEM/WB, so a load-use pair needs one NOP.
REQ-025 Macro CPU_FORWARD_EN undefined: no forwarding or interlock; a consumer reads a stale register unless 2 or more independent instructions separate it from its producer.

Verification
REQ-026 Reset: RST=1 for one CLK -> ADDR=0, CS=0, CS_P=1, WR_RD=0; first fetch at ADDR=0.
REQ-027 Timing: with NOP program, ADDR steps 0,1,2... once per 32 CLK; CS_P=1 for 16 CLK of each period.
REQ-028 Program with 2 NOPs between dependents: LW r1..r4 = 4001,2001,5001,3001; SUB r5=r1-r2; SUB r6=r3-r4; MUL r7=r5*r6; SW r7 to 0x1B2F -> ADDR=0x1B2F, WR_RD=1, Data_BUS_WRITE=4000000.
REQ-029 Same program without NOPs, CPU_FORWARD_EN undefined -> SW to 0x1B2F with value not equal to 4000000; defined (one NOP after the last LW) -> 4000000.
REQ-030 Arithmetic edges: ADD 0xFFFFFFFF+1 -> 0; MUL 0xFFFF*0xFFFF -> 0xFFFE0001; write to r0 then read -> 0.
REQ-031 Assert RST during a MUL's EX cycle -> no SW issued, outputs at reset values, restart at PC=0.
